// File: rtl/uart_rx_buffer.sv
// ----------------------------------------------------------------------------
// uart_rx_buffer
//
// Receive-side buffer between the uart receiver and the consumer of bytes.
// A three-state capture FSM acknowledges each byte with a rdy_clr pulse and
// writes it into a power-of-two FIFO. The FIFO exposes a first-word-fall-
// through read port with level and sticky overflow status.
//
// Valid/ready contract: the receiver holds uart_rdy (with uart_dout stable)
// until it sees uart_rdy_clr; the byte is taken on the edge that samples
// uart_rdy=1 in IDLE, and a new byte is only accepted after uart_rdy has been
// seen low again. On the read side, rd_data is valid whenever empty=0 and the
// head entry is consumed on every edge that samples rd_en=1 with empty=0.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   uart_rdy         receiver has a byte
//   uart_dout[7:0]   received byte, valid while uart_rdy
//   uart_rdy_clr     registered one-cycle acknowledge to the receiver
//   rd_en            pop the head entry
//   rd_data[7:0]     head entry, 0 when empty
//   empty, full      FIFO level flags
//   count            number of entries held, 0..depth
//   overflow         sticky: a byte was dropped
//   ovf_clr          clears overflow (a simultaneous drop wins)
//   dbg_state[1:0]   capture FSM state (0 IDLE, 1 ACK, 2 WAIT)
// ----------------------------------------------------------------------------
module uart_rx_buffer #(
   parameter int depth    = 16,
   parameter int ptr_bits = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                uart_rdy,
   input  logic [7:0]          uart_dout,
   output logic                uart_rdy_clr,
   input  logic                rd_en,
   output logic [7:0]          rd_data,
   output logic                empty,
   output logic                full,
   output logic [ptr_bits:0]   count,
   output logic                overflow,
   input  logic                ovf_clr,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACK  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam logic [ptr_bits:0] C_DEPTH = (ptr_bits + 1)'(depth);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_capture;
   logic                w_push;
   logic                w_pop;
   logic                w_drop;
   logic                r_rdy_clr;
   logic                r_overflow;
   logic [ptr_bits-1:0] r_wr_ptr;
   logic [ptr_bits-1:0] r_rd_ptr;
   logic [ptr_bits:0]   r_count;
   logic [7:0]          r_mem [depth];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (uart_rdy) begin
               w_capture   = 1'b1;
               w_state_nxt = S_ACK;
            end
         end
         S_ACK:  w_state_nxt = S_WAIT;
         // Holding here until rdy drops keeps a late-falling rdy from
         // being taken as a second byte.
         S_WAIT: if (!uart_rdy) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------ push / pop
   // A full FIFO still accepts a byte if the head is popped on the same edge.
   assign w_pop  = rd_en && !empty;
   assign w_push = w_capture && (!full || rd_en);
   assign w_drop = w_capture && !w_push;

   // Acknowledge is driven from a flop so the receiver sees no combinational
   // path from any input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rdy_clr <= 1'b0;
      else        r_rdy_clr <= w_capture;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is not reset: contents are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= uart_dout;
   end

   // Set wins over a simultaneous clear so a drop is never missed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_overflow <= 1'b0;
      else if (w_drop)  r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
   end

   // ---------------------------------------------------------- outputs
   assign uart_rdy_clr = r_rdy_clr;
   assign count        = r_count;
   assign empty        = (r_count == '0);
   assign full         = (r_count == C_DEPTH);
   assign rd_data      = empty ? 8'h00 : r_mem[r_rd_ptr];
   assign overflow     = r_overflow;
   assign dbg_state    = r_state;

endmodule
